pipe_slice_dp_spec: RTL and testbench

PIPE_SLICE_DP_SPEC -- requirements
Module: pipe_slice_dp

---
 rtl/pipe_slice_dp_spec.sv | 70 +++++++
 tb/tb_pipe_slice_dp_spec.sv | 136 +++++++++++++
 2 files changed

// File: rtl/pipe_slice_dp_spec.sv
// One registered slice of a Q1.31 power-series evaluator:
// sum +/- num*coef, num*x, with saturation and overflow chaining.
module pipe_slice_dp_spec #(
   parameter logic [31:0] RAM_VALUE_0 = 32'h7FFFFFFF,
   parameter logic [31:0] RAM_VALUE_1 = 32'h40000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] in_x,
   input  logic [31:0] in_num,
   input  logic [31:0] in_sum,
   input  logic        addr,
   input  logic        sel_sum,
   input  logic        in_overflow,
   output logic [31:0] out_sum,
   output logic [31:0] out_num,
   output logic [31:0] out_x,
   output logic        out_overflow
);

   // Returns {ovf, q31}; only -1.0 * -1.0 can leave the Q1.31 range.
   function automatic logic [32:0] q31_mul(input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [63:0] p;
      p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      if (p[63] != p[62])
         q31_mul = {1'b1, 32'h7FFFFFFF};
      else
         q31_mul = {1'b0, p[62:31]};
   endfunction

   logic [31:0] coef;
   logic [32:0] term_r;
   logic [32:0] num_r;
   logic [32:0] raw;
   logic [31:0] sum;
   logic        add_ovf;

   always_comb begin
      coef = addr ? RAM_VALUE_1 : RAM_VALUE_0;
      term_r = q31_mul(in_num, coef);
      num_r = q31_mul(in_num, in_x);
      if (sel_sum)
         raw = {in_sum[31], in_sum} - {term_r[31], term_r[31:0]};
      else
         raw = {in_sum[31], in_sum} + {term_r[31], term_r[31:0]};
      add_ovf = raw[32] != raw[31];
      if (!add_ovf)
         sum = raw[31:0];
      else if (raw[32])
         sum = 32'h80000000;
      else
         sum = 32'h7FFFFFFF;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_sum      <= '0;
         out_num      <= '0;
         out_x        <= '0;
         out_overflow <= 1'b0;
      end else begin
         out_sum      <= sum;
         out_num      <= num_r[31:0];
         out_x        <= in_x;
         out_overflow <= in_overflow | add_ovf | term_r[32] | num_r[32];
      end
   end

endmodule

// File: tb/tb_pipe_slice_dp_spec.sv
// Directed-vector bench for pipe_slice_dp_spec with hand-computed
// Q1.31 results; coefficient 1 overridden to -0.5.
module tb_pipe_slice_dp_spec;

   logic        clk;
   logic        rst;
   logic [31:0] in_x;
   logic [31:0] in_num;
   logic [31:0] in_sum;
   logic        addr;
   logic        sel_sum;
   logic        in_overflow;
   logic [31:0] out_sum;
   logic [31:0] out_num;
   logic [31:0] out_x;
   logic        out_overflow;

   int n_chk;
   int n_pass;

   pipe_slice_dp_spec #(
      .RAM_VALUE_0(32'h7FFFFFFF),
      .RAM_VALUE_1(32'hC0000000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_x        (in_x),
      .in_num      (in_num),
      .in_sum      (in_sum),
      .addr        (addr),
      .sel_sum     (sel_sum),
      .in_overflow (in_overflow),
      .out_sum     (out_sum),
      .out_num     (out_num),
      .out_x       (out_x),
      .out_overflow(out_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic drive(input logic [31:0] x, input logic [31:0] num,
                        input logic [31:0] sum, input logic a,
                        input logic s, input logic ov);
      @(negedge clk);
      in_x = x;
      in_num = num;
      in_sum = sum;
      addr = a;
      sel_sum = s;
      in_overflow = ov;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_all(input string tag, input logic [31:0] es,
                             input logic [31:0] en, input logic [31:0] ex,
                             input logic eo);
      chk({tag, ".sum"}, out_sum, es);
      chk({tag, ".num"}, out_num, en);
      chk({tag, ".x"}, out_x, ex);
      chk({tag, ".ovf"}, {31'd0, out_overflow}, {31'd0, eo});
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      rst = 1'b1;
      in_x = 32'h12345678;
      in_num = 32'h7FFFFFFF;
      in_sum = 32'h7FFFFFFF;
      addr = 1'b0;
      sel_sum = 1'b0;
      in_overflow = 1'b1;
      @(posedge clk);
      #1;
      expect_all("reset", 32'h0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // 0.5 * -0.5 accumulated onto 0; 0.5 * 0.5 power
      drive(32'h40000000, 32'h40000000, 32'h0, 1'b1, 1'b0, 1'b0);
      expect_all("basic", 32'hE0000000, 32'h20000000, 32'h40000000, 1'b0);

      drive(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0);
      expect_all("pos_sat", 32'h7FFFFFFF, 32'h7FFFFFFE, 32'h7FFFFFFF, 1'b1);

      // overflow must not hold by itself
      drive(32'hC0000000, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0);
      expect_all("neg_x", 32'h7FFFFFFE, 32'hC0000000, 32'hC0000000, 1'b0);

      drive(32'h0, 32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b0);
      expect_all("neg_sat", 32'h80000000, 32'h0, 32'h0, 1'b1);

      drive(32'hC0000000, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b0, 1'b1);
      expect_all("chain", 32'h7FFFFFFE, 32'hC0000000, 32'hC0000000, 1'b1);

      // -1.0 * -1.0 saturates; term -1.0 * (1-2^-31) = 0x80000001
      drive(32'h80000000, 32'h80000000, 32'h0, 1'b0, 1'b0, 1'b0);
      expect_all("mul_sat", 32'h80000001, 32'h7FFFFFFF, 32'h80000000, 1'b1);

      // subtract with negative coefficient: 0.125 - (-0.5) = 0.625
      drive(32'h0, 32'h7FFFFFFF, 32'h10000000, 1'b1, 1'b1, 1'b0);
      expect_all("sub_c1", 32'h50000000, 32'h0, 32'h0, 1'b0);

      // mid-stream reset with live data on the inputs
      @(negedge clk);
      in_x = 32'h40000000;
      in_num = 32'h40000000;
      in_sum = 32'h0;
      addr = 1'b1;
      sel_sum = 1'b0;
      in_overflow = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      expect_all("mid_rst", 32'h0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      drive(32'h40000000, 32'h40000000, 32'h0, 1'b1, 1'b0, 1'b0);
      expect_all("post_rst", 32'hE0000000, 32'h20000000, 32'h40000000, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
